// File: rtl/loadable_downcounter_5bit_if.sv
// -----------------------------------------------------------------------------
// loadable_downcounter_5bit_if
//
// Purpose: groups the control and status signals of the 5-bit loadable
//          down-counter into one bundle. Clock and reset stay outside as
//          plain ports of the counter.
//
// Signals:
//   load     master -> slave  synchronous load strobe
//   data_in  master -> slave  5-bit start/reload value
//   en       master -> slave  count enable
//   count    slave -> master  current counter value (registered)
//   tc       slave -> master  one-cycle terminal-count pulse (registered)
//   busy     slave -> master  counter is in RUN
//   done     slave -> master  counter is in EXPIRED
// -----------------------------------------------------------------------------
interface loadable_downcounter_5bit_if;
    logic       load;
    logic [4:0] data_in;
    logic       en;
    logic [4:0] count;
    logic       tc;
    logic       busy;
    logic       done;

    modport master (
        output load, data_in, en,
        input  count, tc, busy, done
    );

    modport slave (
        input  load, data_in, en,
        output count, tc, busy, done
    );
endinterface

// File: rtl/loadable_downcounter_5bit.sv
// -----------------------------------------------------------------------------
// loadable_downcounter_5bit
//
// Purpose: 5-bit loadable down-counter with a three-state controller
//          (IDLE / RUN / EXPIRED). A load captures data_in into both the
//          counter and a reload register. While RUN and enabled, the counter
//          decrements. The step from 1 produces a one-cycle tc pulse.
//
//          The default build is one-shot: after that step the count sits at 0
//          in EXPIRED until the next load. Defining the macro
//          LOADABLE_DOWNCOUNTER_AUTO_RELOAD_EN changes that step to reload from
//          the reload register and stay in RUN, so tc pulses periodically.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-low reset
//   bus   slave modport of loadable_downcounter_5bit_if
//         (load, data_in, en in; count, tc, busy, done out)
// -----------------------------------------------------------------------------
module loadable_downcounter_5bit (
    input  logic                         clk,
    input  logic                         rst,
    loadable_downcounter_5bit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] count_q, count_d;
    logic [4:0] reload_q, reload_d;
    logic       tc_q, tc_d;

    // State register. Every piece of state, including the reload register,
    // clears asynchronously so the outputs drop without waiting for clk.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Next-state and next-value logic.
    // NOTE: every variable gets a hold/default value before any branch; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (bus.load) begin
            // A load wins over enable, counting and terminal-count handling.
            count_d  = bus.data_in;
            reload_d = bus.data_in;
            state_d  = (bus.data_in != 5'd0) ? RUN : IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.en) begin
                        if (count_q > 5'd1) begin
                            count_d = count_q - 5'd1;
                        end else begin
                            // Terminal step. The count is never 0 in RUN, so
                            // this branch only ever sees 1 and cannot wrap.
                            tc_d = 1'b1;
`ifdef LOADABLE_DOWNCOUNTER_AUTO_RELOAD_EN
                            count_d = reload_q;
`else
                            count_d = 5'd0;
                            state_d = EXPIRED;
`endif
                        end
                    end
                end
                IDLE, EXPIRED: begin
                    // Both states hold the count; en has no effect here.
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == EXPIRED);

endmodule

// File: tb/tb_loadable_downcounter_5bit.sv
// -----------------------------------------------------------------------------
// tb_loadable_downcounter_5bit
//
// Directed bench for loadable_downcounter_5bit. Each step drives inputs on the
// falling edge and pushes the hand-derived expected outputs for the next rising
// edge onto a scoreboard queue. The entry is popped and compared 1 ns after
// that edge. The expectations follow the default one-shot build, or the
// auto-reload build when LOADABLE_DOWNCOUNTER_AUTO_RELOAD_EN is defined.
// -----------------------------------------------------------------------------
module tb_loadable_downcounter_5bit;

    typedef struct packed {
        logic [4:0] count;
        logic       tc;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    loadable_downcounter_5bit_if bus ();

    loadable_downcounter_5bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t observe();
        exp_t o;
        o.count = bus.count;
        o.tc    = bus.tc;
        o.busy  = bus.busy;
        o.done  = bus.done;
        return o;
    endfunction

    task automatic check(input string tag, input exp_t obs, input exp_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed count=%0d tc=%b busy=%b done=%b expected count=%0d tc=%b busy=%b done=%b",
                   tag, obs.count, obs.tc, obs.busy, obs.done,
                   exp.count, exp.tc, exp.busy, exp.done);
        end
    endtask

    // One clock step: drive, queue the expectation, then compare after the edge.
    task automatic step(input string tag, input logic ld, input logic [4:0] d,
                        input logic e, input logic [4:0] c, input logic t,
                        input logic b, input logic dn);
        exp_t x;
        @(negedge clk);
        bus.load    = ld;
        bus.data_in = d;
        bus.en      = e;
        sb.push_back('{count: c, tc: t, busy: b, done: dn});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check(tag, observe(), x);
    endtask

    initial begin
        rst         = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = 5'd0;
        bus.en      = 1'b0;

        // Reset state, sampled before the first clock edge.
        #2;
        check("reset_state", observe(), '{count: 5'd0, tc: 1'b0, busy: 1'b0, done: 1'b0});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Out of reset the block waits in IDLE whatever en does.
        step("idle_after_reset", 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);

`ifndef LOADABLE_DOWNCOUNTER_AUTO_RELOAD_EN
        // Load 5 then count down to 0 with tc on the final edge.
        step("ld5_load",  1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
        step("ld5_c4",    1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0);
        step("ld5_c3",    1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
        step("ld5_c2",    1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0);
        step("ld5_c1",    1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
        step("ld5_tc",    1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1);
        step("exp_hold1", 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        step("exp_hold2", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Load 6 with a three-cycle enable gap; tc on the 6th enabled edge.
        step("ld6_load",  1'b1, 5'd6, 1'b0, 5'd6, 1'b0, 1'b1, 1'b0);
        step("ld6_c5",    1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
        step("ld6_c4",    1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0);
        step("ld6_hold1", 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0);
        step("ld6_hold2", 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0);
        step("ld6_hold3", 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0);
        step("ld6_c3",    1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
        step("ld6_c2",    1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0);
        step("ld6_c1",    1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
        step("ld6_tc",    1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1);

        // Reload from EXPIRED, then overwrite with 27 mid-count at 10.
        step("ld12_load", 1'b1, 5'd12, 1'b1, 5'd12, 1'b0, 1'b1, 1'b0);
        step("ld12_c11",  1'b0, 5'd0,  1'b1, 5'd11, 1'b0, 1'b1, 1'b0);
        step("ld12_c10",  1'b0, 5'd0,  1'b1, 5'd10, 1'b0, 1'b1, 1'b0);
        step("ld27_mid",  1'b1, 5'd27, 1'b1, 5'd27, 1'b0, 1'b1, 1'b0);
        step("ld27_c26",  1'b0, 5'd0,  1'b1, 5'd26, 1'b0, 1'b1, 1'b0);

        // Load 0 from RUN goes straight to IDLE and never pulses tc.
        step("ld0_load",  1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step("ld0_hold",  1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);

        // Boundary values: load 1 expires on the first enabled edge; 31 counts.
        step("ld1_load",  1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
        step("ld1_tc",    1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1);
        step("ld1_after", 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        step("ld31_load", 1'b1, 5'd31, 1'b1, 5'd31, 1'b0, 1'b1, 1'b0);
        step("ld31_c30",  1'b0, 5'd0,  1'b1, 5'd30, 1'b0, 1'b1, 1'b0);
`else
        // Auto-reload: period 3 with tc at cycles 3, 6, 9 and 12; never EXPIRED.
        step("ar3_load",  1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 4; p++) begin
            step("ar3_c2", 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0);
            step("ar3_c1", 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
            step("ar3_tc", 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        end
        step("ar3_hold",  1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);

        // Load during RUN starts a new period; reload=1 gives back-to-back tc.
        step("ar1_load",  1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
        step("ar1_tc1",   1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0);
        step("ar1_tc2",   1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0);
        step("ar1_gap",   1'b0, 5'd0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0);

        // Load 0 from RUN goes to IDLE.
        step("ld0_load",  1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step("ld0_hold",  1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
`endif

        // Asynchronous reset mid-count at 3: outputs clear before any edge.
        step("rst_ld5",   1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
        step("rst_c4",    1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0);
        step("rst_c3",    1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", observe(), '{count: 5'd0, tc: 1'b0, busy: 1'b0, done: 1'b0});
        @(negedge clk);
        rst = 1'b1;

        // After release: IDLE, no tc, en ignored until a load.
        step("rst_idle1", 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step("rst_idle2", 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step("rst_idle3", 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/loadable_downcounter_5bit.md
LOADABLE_DOWNCOUNTER_5BIT -- requirements
Module: loadable_downcounter_5bit

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; all other state changes SHALL occur on the rising edge of clk.
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 rst  input  1  asynchronous active-low reset (rst=0 resets).
REQ-004 load  input  1  synchronous load strobe; captures data_in.
REQ-005 data_in  input  5  start/reload value, unsigned 0..31.
REQ-006 en  input  1  count enable; decrement only while en=1.
REQ-007 count  output  5  current counter value, registered.
REQ-008 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-009 busy  output  1  high while state=RUN.
REQ-010 done  output  1  high while state=EXPIRED.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and EXPIRED, with busy=(RUN) and done=(EXPIRED) decoded from the state register only.
REQ-012 The block SHALL hold a 5-bit reload register, written only by load.
REQ-013 load=1 SHALL, in any state, set count<=data_in and reload<=data_in at the same edge.
REQ-014 load=1 SHALL override en, counting and terminal-count handling in the same cycle, and SHALL force tc=0 on that edge.
REQ-015 load=1 with data_in!=0 SHALL move the FSM to RUN; load=1 with data_in=0 SHALL move it to IDLE with count=0.
REQ-016 In RUN, with en=1 and count>1, the block SHALL set count<=count-1 each cycle.
REQ-017 In RUN, with en=0, the block SHALL hold count and state, and SHALL hold tc at 0.
REQ-018 In RUN, with en=1 and count=1, the block SHALL set count<=0 and tc<=1 on that edge, then go to EXPIRED (REQ-029 governs the macro-enabled case).
REQ-019 A load of value N (N>=1) followed by continuous en=1 SHALL assert tc exactly N cycles after the load edge.
REQ-020 tc SHALL deassert on the next edge after it asserts, unless REQ-029 re-asserts it.
REQ-021 In EXPIRED, the block SHALL hold count=0 regardless of en until load; count SHALL never wrap from 0 to 31.
REQ-022 In IDLE, the block SHALL hold count regardless of en.
REQ-023 en SHALL have no effect outside RUN.

Reset
REQ-024 rst=0 SHALL immediately, without waiting for clk, force count=0, reload=0, tc=0 and state=IDLE, so busy=0 and done=0.
REQ-025 Reset asserted mid-count SHALL abort the count with no tc pulse.
REQ-026 After rst returns to 1, the block SHALL stay in IDLE until the first load.

Configuration
REQ-027 The feature macro SHALL be named LOADABLE_DOWNCOUNTER_AUTO_RELOAD_EN.
REQ-028 With the macro undefined, the block SHALL behave as one-shot per REQ-018/021.
REQ-029 With the macro defined, RUN with en=1 and count=1 SHALL set count<=reload and tc<=1 and SHALL remain in RUN; EXPIRED SHALL be unreachable, and tc SHALL pulse every reload cycles while en=1.
REQ-030 With the macro defined, tc SHALL be able to assert on consecutive cycles when reload=1.
REQ-031 With the macro defined, a load during RUN SHALL take effect on the next period immediately, per REQ-013.

Verification
REQ-032 Reset, load data_in=5, en=1 -> count 5,4,3,2,1,0; tc=1 only on the edge where count becomes 0; done=1 afterward; count stays 0.
REQ-033 load 6, en=1 for 2 cycles, en=0 for 3 cycles, then en=1 -> count 6,5,4,4,4,4,3,...; tc 6 enabled cycles after the load.
REQ-034 load 27 while count=10 in RUN -> count=27 next edge, no tc, busy stays 1.
REQ-035 load 0 -> state IDLE, count=0, busy=0, done=0, tc never asserts.
REQ-036 Drop rst to 0 asynchronously mid-count at count=3 -> outputs zero before the next clk edge; no tc after release.
REQ-037 Macro defined, load 3, en=1 for 12 cycles -> tc pulses at cycles 3,6,9,12; count sequence 3,2,1,3,2,1...; done never 1.
